// File: rtl/huff_pkg.sv
// Shared Huffman types and width helpers; also used by the code-map builder.
package huff_pkg;

    typedef enum logic [1:0] {IDLE, ENCODE, FLUSH} huff_state_e;

    localparam int SYM_W_DEF   = 3;
    localparam int MAX_LEN_DEF = 7;
    localparam int OUT_W_DEF   = 8;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic int nbits_w(input int out_w);
        return $clog2(out_w + 1);
    endfunction

    localparam int LEN_W   = len_w(MAX_LEN_DEF);
    localparam int NBITS_W = nbits_w(OUT_W_DEF);

endpackage

// File: rtl/huff_bit_packer.sv
// MSB-first bit accumulator: appends variable-length codes below the fill
// point and emits OUT_W-bit words over a valid/ready handshake.
module huff_bit_packer
    import huff_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int LW      = len_w(MAX_LEN),
    parameter int NBW     = nbits_w(OUT_W)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               app_en_i,
    input  logic [LW-1:0]      app_len_i,
    input  logic [MAX_LEN-1:0] app_code_i,
    input  logic               flush_i,
    output logic               room_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [OUT_W-1:0]   out_data_o,
    output logic               out_last_o,
    output logic [NBW-1:0]     out_nbits_o
);

    localparam int ACC_W = OUT_W + MAX_LEN;
    localparam int FW    = $clog2(ACC_W + 1);
    localparam logic [FW-1:0] OUT_WF = FW'(OUT_W);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [ACC_W-1:0] ins;

    assign room_o      = fill_q < OUT_WF;
    assign out_valid_o = (fill_q >= OUT_WF) || flush_i;
    assign out_data_o  = acc_q[ACC_W-1 -: OUT_W];
    assign out_last_o  = flush_i && (fill_q <= OUT_WF);
    assign out_nbits_o = (fill_q >= OUT_WF) ? NBW'(OUT_W) : NBW'(fill_q);

    // Left-shifting by MAX_LEN-len drops any code bits above len, then the
    // right shift places the code just below the current fill.
    assign ins = (ACC_W'({app_code_i, {OUT_W{1'b0}}}) << (MAX_LEN - int'(app_len_i))) >> fill_q;

    always_comb begin
        acc_d  = acc_q;
        fill_d = fill_q;
        if (out_valid_o && out_ready_i) begin
            acc_d  = acc_q << OUT_W;
            fill_d = (fill_q >= OUT_WF) ? fill_q - OUT_WF : '0;
        end else if (app_en_i) begin
            acc_d  = acc_q | ins;
            fill_d = fill_q + FW'(app_len_i);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= '0;
            fill_q <= '0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/huff_stream_encoder.sv
// Huffman stream encoder top: code table, block FSM, error/bit-count tracking.
// Optional HUFF_BITCNT_EN adds a per-block appended-bit counter port.
module huff_stream_encoder
    import huff_pkg::*;
#(
    parameter  int SYM_W   = SYM_W_DEF,
    parameter  int MAX_LEN = MAX_LEN_DEF,
    parameter  int OUT_W   = OUT_W_DEF,
    localparam int LW      = len_w(MAX_LEN),
    localparam int NBW     = nbits_w(OUT_W)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               tbl_we,
    input  logic [SYM_W-1:0]   tbl_sym,
    input  logic [LW-1:0]      tbl_len,
    input  logic [MAX_LEN-1:0] tbl_code,
    input  logic               sym_valid,
    output logic               sym_ready,
    input  logic [SYM_W-1:0]   sym_data,
    input  logic               sym_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_last,
    output logic [NBW-1:0]     out_nbits,
`ifdef HUFF_BITCNT_EN
    output logic [31:0]        bit_count,
`endif
    output logic               err_unmapped
);

    localparam int NSYM = 2 ** SYM_W;

    logic [LW-1:0]      len_q  [NSYM];
    logic [MAX_LEN-1:0] code_q [NSYM];
    huff_state_e        state_q, state_d;
    logic               err_q, err_d;
    logic               init_q;
    logic               room;
    logic               sym_hs;
    logic               unmapped;
    logic [LW-1:0]      lk_len;
    logic [MAX_LEN-1:0] lk_code;

    assign lk_len   = len_q[sym_data];
    assign lk_code  = code_q[sym_data];
    assign unmapped = (lk_len == '0);
    // init_q keeps sym_ready low while reset is held and for the release cycle.
    assign sym_ready    = init_q && (state_q != FLUSH) && room;
    assign sym_hs       = sym_valid && sym_ready;
    assign err_unmapped = err_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NSYM; i++) begin
                len_q[i]  <= '0;
                code_q[i] <= '0;
            end
        end else if (tbl_we && state_q == IDLE) begin
            len_q[tbl_sym]  <= tbl_len;
            code_q[tbl_sym] <= tbl_code;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (sym_hs) begin
                state_d = sym_last ? FLUSH : ENCODE;
                err_d   = unmapped;
            end
            ENCODE: if (sym_hs) begin
                err_d = err_q | unmapped;
                if (sym_last) state_d = FLUSH;
            end
            FLUSH: if (out_valid && out_ready && out_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            init_q  <= 1'b1;
        end
    end

`ifdef HUFF_BITCNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (sym_hs) cnt_d = ((state_q == IDLE) ? 32'd0 : cnt_q) + 32'(lk_len);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign bit_count = cnt_q;
`endif

    huff_bit_packer #(
        .MAX_LEN (MAX_LEN),
        .OUT_W   (OUT_W),
        .LW      (LW),
        .NBW     (NBW)
    ) u_packer (
        .clock       (clock),
        .reset_n     (reset_n),
        .app_en_i    (sym_hs),
        .app_len_i   (lk_len),
        .app_code_i  (lk_code),
        .flush_i     (state_q == FLUSH),
        .room_o      (room),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_nbits_o (out_nbits)
    );

endmodule

// File: tb/tb_huff_stream_encoder.sv
// Directed bench for huff_stream_encoder with default parameters.
module tb_huff_stream_encoder;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       tbl_we = 1'b0;
    logic [2:0] tbl_sym = '0;
    logic [2:0] tbl_len = '0;
    logic [6:0] tbl_code = '0;
    logic       sym_valid = 1'b0;
    logic       sym_ready;
    logic [2:0] sym_data = '0;
    logic       sym_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic [3:0] out_nbits;
    logic       err_unmapped;
`ifdef HUFF_BITCNT_EN
    logic [31:0] bit_count;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] qd[$];
    logic [3:0] qn[$];
    logic       ql[$];

    always #5 clock = ~clock;

    huff_stream_encoder dut (
        .clock(clock), .reset_n(reset_n),
        .tbl_we(tbl_we), .tbl_sym(tbl_sym), .tbl_len(tbl_len), .tbl_code(tbl_code),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data), .sym_last(sym_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_nbits(out_nbits),
`ifdef HUFF_BITCNT_EN
        .bit_count(bit_count),
`endif
        .err_unmapped(err_unmapped)
    );

    always @(posedge clock)
        if (reset_n && out_valid && out_ready) begin
            qd.push_back(out_data);
            qn.push_back(out_nbits);
            ql.push_back(out_last);
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int s, input int len, input int code);
        @(negedge clock);
        tbl_we = 1'b1; tbl_sym = 3'(s); tbl_len = 3'(len); tbl_code = 7'(code);
        @(negedge clock);
        tbl_we = 1'b0;
    endtask

    task automatic send(input int s, input bit last);
        int n = 0;
        @(negedge clock);
        sym_valid = 1'b1; sym_data = 3'(s); sym_last = last;
        while (!sym_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("send_timeout", 32'(n < 100), 32'd1);
        @(posedge clock);
        #1;
        sym_valid = 1'b0; sym_last = 1'b0;
    endtask

    task automatic wait_words(input string tag, input int n);
        int c = 0;
        while (qd.size() < n && c < 200) begin
            @(negedge clock);
            c++;
        end
        chk(tag, 32'(qd.size()), 32'(n));
    endtask

    task automatic chk_word(input string tag, input int i, input int d, input int nb, input int l);
        if (i < qd.size()) begin
            chk({tag, "_data"}, 32'(qd[i]), 32'(d));
            chk({tag, "_nbits"}, 32'(qn[i]), 32'(nb));
            chk({tag, "_last"}, 32'(ql[i]), 32'(l));
        end else begin
            chk({tag, "_missing"}, 32'(qd.size()), 32'(i + 1));
        end
    endtask

    task automatic clrq();
        qd.delete(); qn.delete(); ql.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sym_ready"}, 32'(sym_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_out_last"}, 32'(out_last), 32'd0);
        chk({tag, "_out_nbits"}, 32'(out_nbits), 32'd0);
        chk({tag, "_err"}, 32'(err_unmapped), 32'd0);
    endtask

    initial begin
        // reset state
        #1;
        chk_all_zero("rst");
        @(negedge clock); @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle_ready", 32'(sym_ready), 32'd1);

        wr(0, 1, 7'b0);
        wr(1, 2, 7'b10);
        wr(2, 3, 7'b110);
        wr(3, 3, 7'b111);

        // 1: 0,1,2,3 -> 0x5B, 0x80/1 last
        out_ready = 1'b1;
        clrq();
        send(0, 0); send(1, 0); send(2, 0); send(3, 1);
        chk("t1_lat_valid", 32'(out_valid), 32'd1);
        chk("t1_lat_data", 32'(out_data), 32'h5B);
`ifdef HUFF_BITCNT_EN
        chk("t1_bitcount", bit_count, 32'd9);
`endif
        wait_words("t1_cnt", 2);
        chk_word("t1_w0", 0, 8'h5B, 8, 0);
        chk_word("t1_w1", 1, 8'h80, 1, 1);
        chk("t1_err", 32'(err_unmapped), 32'd0);

        // 2: eight sym0 -> single full last word, no empty word after
        clrq();
        for (int i = 0; i < 8; i++) send(0, i == 7);
        wait_words("t2_cnt", 1);
        repeat (5) @(negedge clock);
        chk("t2_no_extra", 32'(qd.size()), 32'd1);
        chk_word("t2_w0", 0, 8'h00, 8, 1);
        chk("t2_idle_ready", 32'(sym_ready), 32'd1);

        // 3: backpressure with sym3 stream
        clrq();
        out_ready = 1'b0;
        send(3, 0); send(3, 0); send(3, 0);
        @(negedge clock);
        sym_valid = 1'b1; sym_data = 3'd3; sym_last = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("t3_stall_ready", 32'(sym_ready), 32'd0);
            chk("t3_stall_valid", 32'(out_valid), 32'd1);
            chk("t3_stall_data", 32'(out_data), 32'hFF);
        end
        out_ready = 1'b1;
        send(3, 0); send(3, 0); send(3, 0); send(3, 0); send(3, 1);
        wait_words("t3_cnt", 3);
        chk_word("t3_w0", 0, 8'hFF, 8, 0);
        chk_word("t3_w1", 1, 8'hFF, 8, 0);
        chk_word("t3_w2", 2, 8'hFF, 8, 1);

        // 4: unmapped sym5 mid-block
        clrq();
        send(2, 0);
        chk("t4_err_pre", 32'(err_unmapped), 32'd0);
        send(5, 0);
        chk("t4_err_set", 32'(err_unmapped), 32'd1);
        send(3, 0); send(1, 1);
        wait_words("t4_cnt", 1);
        chk_word("t4_w0", 0, 8'hDE, 8, 1);
        chk("t4_err_sticky", 32'(err_unmapped), 32'd1);

        // 6: table write during ENCODE is ignored
        clrq();
        send(0, 0);
        chk("t6_err_clear", 32'(err_unmapped), 32'd0);
        wr(0, 2, 7'b11);
        send(0, 0); send(1, 1);
        wait_words("t6_cnt", 1);
        chk_word("t6_w0", 0, 8'h20, 4, 1);

        // 5: reset during FLUSH
        clrq();
        out_ready = 1'b0;
        send(3, 0); send(3, 1);
        chk("t5_flush_valid", 32'(out_valid), 32'd1);
        chk("t5_flush_last", 32'(out_last), 32'd1);
        chk("t5_flush_nbits", 32'(out_nbits), 32'd6);
        chk("t5_flush_data", 32'(out_data), 32'hFC);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk_all_zero("t5_rst");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("t5_ready", 32'(sym_ready), 32'd1);
        out_ready = 1'b1;
        send(0, 1);
        chk("t5_err", 32'(err_unmapped), 32'd1);
        wait_words("t5_cnt", 1);
        chk_word("t5_w0", 0, 8'h00, 0, 1);
        repeat (3) @(negedge clock);
        chk("t5_no_extra", 32'(qd.size()), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
